// File: rtl/keypad_code_entry.sv
// keypad_code_entry: scans and debounces a 4x4 matrix keypad and assembles the
// two-digit product code (digits 0..3) that is confirmed with '#' or cleared with '*'.
module keypad_code_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  output logic [1:0] num1,
  output logic [1:0] num2,
  output logic [1:0] digits,
  output logic       entering,
  output logic       key_strobe,
  output logic       code_valid,
  output logic       code_error
);
  // state | meaning
  // IDLE  | no digits entered (num1/num2 may still hold the last confirmed code)
  // ONE   | first digit captured in num1
  // TWO   | both digits captured, waiting for '#'
  typedef enum logic [1:0] {IDLE, ONE, TWO} state_t;

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [3:0]    cols_meta, cols_sync;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    row_idx;
  logic          slot_end, frame_end;
  logic [1:0]    frame_hits;
  logic [3:0]    frame_key;
  logic [2:0]    row_hits, hits_sum;
  logic [1:0]    row_col, hits_sat;
  logic [3:0]    key_sel;
  logic [4:0]    frame_res;
  logic [4:0]    prev_res, stable;
  logic [DW-1:0] match_cnt, match_nxt;
  logic [3:0]    key_code;
  logic          is_star, is_hash, is_digit;
  logic [3:0]    digit_val;
  state_t        state;
  logic [TW-1:0] idle_cnt;

  assign slot_end  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (row_idx == 2'd3);

  // Keys are tracked as {present, row, col}; 5'd0 means no key.
  always_comb begin
    row_hits = '0;
    row_col  = '0;
    for (int c = 0; c < 4; c++) begin
      if (!cols_sync[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(c);
      end
    end
    hits_sum  = {1'b0, frame_hits} + row_hits;
    hits_sat  = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    key_sel   = (row_hits == 3'd1) ? {row_idx, row_col} : frame_key;
    frame_res = (hits_sat == 2'd1) ? {1'b1, key_sel} : 5'd0;
    if (frame_res != prev_res)
      match_nxt = DW'(1);
    else if (match_cnt >= DW'(DEBOUNCE))
      match_nxt = match_cnt;
    else
      match_nxt = match_cnt + DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_meta  <= 4'hF;
      cols_sync  <= 4'hF;
      scan_cnt   <= '0;
      row_idx    <= 2'd0;
      rows       <= 4'b1110;
      frame_hits <= 2'd0;
      frame_key  <= 4'd0;
      prev_res   <= 5'd0;
      stable     <= 5'd0;
      match_cnt  <= '0;
      key_strobe <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      cols_meta  <= cols;
      cols_sync  <= cols_meta;
      key_strobe <= 1'b0;
      if (slot_end) begin
        scan_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        rows     <= ~(4'b0001 << (row_idx + 2'd1));
        if (frame_end) begin
          frame_hits <= 2'd0;
          frame_key  <= 4'd0;
          prev_res   <= frame_res;
          match_cnt  <= match_nxt;
          if (match_nxt >= DW'(DEBOUNCE)) begin
            stable <= frame_res;
            // Only a none->key transition is an event; column 3 (A-D) never strobes.
            if (!stable[4] && frame_res[4] && frame_res[1:0] != 2'd3) begin
              key_strobe <= 1'b1;
              key_code   <= frame_res[3:0];
            end
          end
        end else begin
          frame_hits <= hits_sat;
          frame_key  <= key_sel;
        end
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  always_comb begin
    is_star   = 1'b0;
    is_hash   = 1'b0;
    is_digit  = 1'b0;
    digit_val = 4'd0;
    case (key_code)
      4'd0, 4'd1, 4'd2:  begin is_digit = 1'b1; digit_val = key_code + 4'd1; end
      4'd4, 4'd5, 4'd6:  begin is_digit = 1'b1; digit_val = key_code; end
      4'd8, 4'd9, 4'd10: begin is_digit = 1'b1; digit_val = key_code - 4'd1; end
      4'd12:             is_star = 1'b1;
      4'd13:             begin is_digit = 1'b1; digit_val = 4'd0; end
      4'd14:             is_hash = 1'b1;
      default:           ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      num1       <= 2'd0;
      num2       <= 2'd0;
      digits     <= 2'd0;
      entering   <= 1'b0;
      code_valid <= 1'b0;
      code_error <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      code_valid <= 1'b0;
      code_error <= 1'b0;
      if (key_strobe) begin
        idle_cnt <= '0;
        if (is_star) begin
          state <= IDLE; num1 <= 2'd0; num2 <= 2'd0; digits <= 2'd0; entering <= 1'b0;
        end else if (is_hash) begin
          if (state == TWO) begin
            code_valid <= 1'b1;
            state      <= IDLE;
            digits     <= 2'd0;
            entering   <= 1'b0;
          end else begin
            code_error <= 1'b1;
            state <= IDLE; num1 <= 2'd0; num2 <= 2'd0; digits <= 2'd0; entering <= 1'b0;
          end
        end else if (is_digit && state != TWO) begin
          if (digit_val > 4'd3) begin
            code_error <= 1'b1;
            state <= IDLE; num1 <= 2'd0; num2 <= 2'd0; digits <= 2'd0; entering <= 1'b0;
          end else if (state == IDLE) begin
            num1 <= digit_val[1:0]; num2 <= 2'd0; state <= ONE; digits <= 2'd1; entering <= 1'b1;
          end else begin
            num2 <= digit_val[1:0]; state <= TWO; digits <= 2'd2; entering <= 1'b1;
          end
        end
      end else if (state != IDLE) begin
        // Abandoned entry: discard silently once the idle time runs out.
        if (idle_cnt == TW'(TIMEOUT - 1)) begin
          idle_cnt <= '0;
          state <= IDLE; num1 <= 2'd0; num2 <= 2'd0; digits <= 2'd0; entering <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

endmodule
